// File: rtl/decipher.sv
// XTEA decryption core: runs the Feistel rounds in reverse, one half-round step per clock,
// and presents the recovered plaintext with a sticky completion flag.
module decipher #(
  parameter int unsigned ROUNDS = 32,
  parameter logic [31:0] DELTA  = 32'h9E3779B9
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [31:0]  data_in1,
  input  logic [31:0]  data_in2,
  input  logic [127:0] key_in,
  output logic [31:0]  data_out1,
  output logic [31:0]  data_out2,
  output logic         busy,
  output logic         all_done
);

  // state | meaning
  // IDLE  | waiting for start, nothing run since reset
  // V1    | update workunit2 from workunit1
  // SUM   | step the key schedule back by DELTA
  // V0    | update workunit1 from workunit2, count the round
  // OUT   | publish plaintext, raise all_done
  // DONE  | result held, a new start may be accepted
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    V1   = 3'd1,
    SUM  = 3'd2,
    V0   = 3'd3,
    OUT  = 3'd4,
    DONE = 3'd5
  } state_t;

  localparam logic [63:0] SUM_PROD = 64'(DELTA) * 64'(ROUNDS);
  localparam logic [31:0] SUM_INIT = SUM_PROD[31:0];
  localparam logic [7:0]  ROUNDS_W = 8'(ROUNDS);

  state_t      state;
  logic [31:0] workunit1;
  logic [31:0] workunit2;
  logic [31:0] sum;
  logic [7:0]  x;
  logic [7:0]  x_next;
  logic [31:0] k_v1;
  logic [31:0] k_v0;

  function automatic logic [31:0] key_word(input logic [127:0] k, input logic [1:0] idx);
    case (idx)
      2'd0:    return k[127:96];
      2'd1:    return k[95:64];
      2'd2:    return k[63:32];
      default: return k[31:0];
    endcase
  endfunction

  function automatic logic [31:0] mix(input logic [31:0] v);
    return ((v << 4) ^ (v >> 5)) + v;
  endfunction

  always_comb begin
    k_v1   = key_word(key_in, sum[12:11]);
    k_v0   = key_word(key_in, sum[1:0]);
    x_next = x + 8'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      data_out1 <= '0;
      data_out2 <= '0;
      workunit1 <= '0;
      workunit2 <= '0;
      sum       <= '0;
      x         <= '0;
      busy      <= 1'b0;
      all_done  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            workunit1 <= data_in1;
            workunit2 <= data_in2;
            sum       <= SUM_INIT;
            x         <= '0;
            all_done  <= 1'b0;
            busy      <= 1'b1;
            state     <= V1;
          end
        end
        V1: begin
          workunit2 <= workunit2 - (mix(workunit1) ^ (sum + k_v1));
          state     <= SUM;
        end
        SUM: begin
          sum   <= sum - DELTA;
          state <= V0;
        end
        V0: begin
          // sum was already stepped back in SUM, as the reverse key schedule requires
          workunit1 <= workunit1 - (mix(workunit2) ^ (sum + k_v0));
          x         <= x_next;
          state     <= (x_next == ROUNDS_W) ? OUT : V1;
        end
        OUT: begin
          data_out1 <= workunit1;
          data_out2 <= workunit2;
          all_done  <= 1'b1;
          busy      <= 1'b0;
          state     <= DONE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_decipher.sv
// Directed bench for the XTEA decipher core: reset, round trip against a C-style model,
// key slicing, start-while-busy, mid-run reset and back-to-back runs with one round.
module tb_decipher;

  localparam logic [31:0] DELTA = 32'h9E3779B9;

  logic         clock = 1'b0;
  logic         reset;
  logic         start, start1;
  logic [31:0]  data_in1, data_in2, d1_in1, d1_in2;
  logic [127:0] key_in, key1;
  logic [31:0]  data_out1, data_out2, d1_out1, d1_out2;
  logic         busy, all_done, busy1, all_done1;

  int passed = 0;
  int total  = 0;

  always #5 clock = ~clock;

  decipher dut (
    .clock(clock), .reset(reset), .start(start),
    .data_in1(data_in1), .data_in2(data_in2), .key_in(key_in),
    .data_out1(data_out1), .data_out2(data_out2), .busy(busy), .all_done(all_done)
  );

  decipher #(.ROUNDS(1)) dut1 (
    .clock(clock), .reset(reset), .start(start1),
    .data_in1(d1_in1), .data_in2(d1_in2), .key_in(key1),
    .data_out1(d1_out1), .data_out2(d1_out2), .busy(busy1), .all_done(all_done1)
  );

  function automatic logic [31:0] kw(input logic [127:0] k, input logic [1:0] idx);
    return k[127 - 32*int'(idx) -: 32];
  endfunction

  function automatic logic [63:0] enc_model(input logic [31:0] a0, input logic [31:0] a1,
                                            input logic [127:0] k, input int n);
    logic [31:0] v0, v1, s;
    v0 = a0; v1 = a1; s = 32'd0;
    for (int i = 0; i < n; i++) begin
      v0 += (((v1 << 4) ^ (v1 >> 5)) + v1) ^ (s + kw(k, s[1:0]));
      s  += DELTA;
      v1 += (((v0 << 4) ^ (v0 >> 5)) + v0) ^ (s + kw(k, s[12:11]));
    end
    return {v0, v1};
  endfunction

  function automatic logic [63:0] dec_model(input logic [31:0] a0, input logic [31:0] a1,
                                            input logic [127:0] k, input int n);
    logic [31:0] v0, v1, s;
    v0 = a0; v1 = a1; s = DELTA * 32'(n);
    for (int i = 0; i < n; i++) begin
      v1 -= (((v0 << 4) ^ (v0 >> 5)) + v0) ^ (s + kw(k, s[12:11]));
      s  -= DELTA;
      v0 -= (((v1 << 4) ^ (v1 >> 5)) + v1) ^ (s + kw(k, s[1:0]));
    end
    return {v0, v1};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Accept a block on the next edge and step until all_done rises (bounded);
  // optionally pulse start with other data at edge inj while busy.
  task automatic run32(input logic [31:0] a0, input logic [31:0] a1, input int inj,
                       input logic [31:0] b0, input logic [31:0] b1,
                       output int rise, output int busy_low);
    rise = -1; busy_low = 0;
    data_in1 = a0; data_in2 = a1; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    for (int n = 1; n <= 200; n++) begin
      if (n == inj) begin start = 1'b1; data_in1 = b0; data_in2 = b1; end
      @(negedge clock);
      if (n == inj) begin start = 1'b0; data_in1 = a0; data_in2 = a1; end
      if (all_done) begin rise = n; break; end
      if (!busy) busy_low++;
    end
  endtask

  logic [127:0] key_rt;
  logic [63:0]  ct, exp64, ct_b, exp_a, exp_b;
  int           rise, busy_low;
  logic         ad [0:12];
  logic [31:0]  o4_1, o4_2, o9_1, o9_2;

  initial begin
    reset = 1'b1; start = 1'b0; start1 = 1'b0;
    data_in1 = '0; data_in2 = '0; d1_in1 = '0; d1_in2 = '0;
    key_in = '0; key1 = '0;
    key_rt = 128'h000102030405060708090A0B0C0D0E0F;

    // reset
    repeat (2) @(negedge clock);
    chk("reset_out1", data_out1, 32'h0);
    chk("reset_out2", data_out2, 32'h0);
    chk("reset_busy", {31'b0, busy}, 32'h0);
    chk("reset_done", {31'b0, all_done}, 32'h0);
    reset = 1'b0;
    repeat (10) @(negedge clock);
    chk("idle_out1", data_out1, 32'h0);
    chk("idle_out2", data_out2, 32'h0);
    chk("idle_busy", {31'b0, busy}, 32'h0);
    chk("idle_done", {31'b0, all_done}, 32'h0);

    // round trip
    key_in = key_rt;
    ct = enc_model(32'h41424344, 32'h45464748, key_rt, 32);
    run32(ct[63:32], ct[31:0], -1, 32'h0, 32'h0, rise, busy_low);
    chk("rt_latency", 32'(rise), 32'd97);
    chk("rt_busy_gap", 32'(busy_low), 32'd0);
    chk("rt_out1", data_out1, 32'h41424344);
    chk("rt_out2", data_out2, 32'h45464748);
    chk("rt_busy_low", {31'b0, busy}, 32'h0);
    exp64 = dec_model(ct[63:32], ct[31:0], key_rt, 32);
    chk("rt_model1", data_out1, exp64[63:32]);
    chk("rt_model2", data_out2, exp64[31:0]);
    repeat (3) @(negedge clock);
    chk("rt_hold_out1", data_out1, 32'h41424344);
    chk("rt_hold_done", {31'b0, all_done}, 32'h1);

    // key slices
    key_in = {96'h0, 32'hFFFFFFFF};
    run32(32'h0, 32'h0, -1, 32'h0, 32'h0, rise, busy_low);
    exp64 = dec_model(32'h0, 32'h0, {96'h0, 32'hFFFFFFFF}, 32);
    chk("k3_out1", data_out1, exp64[63:32]);
    chk("k3_out2", data_out2, exp64[31:0]);
    key_in = {32'hFFFFFFFF, 96'h0};
    run32(32'h0, 32'h0, -1, 32'h0, 32'h0, rise, busy_low);
    exp64 = dec_model(32'h0, 32'h0, {32'hFFFFFFFF, 96'h0}, 32);
    chk("k0_out1", data_out1, exp64[63:32]);
    chk("k0_out2", data_out2, exp64[31:0]);

    // start while busy
    key_in = key_rt;
    run32(ct[63:32], ct[31:0], 40, 32'hDEADBEEF, 32'h12345678, rise, busy_low);
    chk("sb_latency", 32'(rise), 32'd97);
    chk("sb_busy_gap", 32'(busy_low), 32'd0);
    chk("sb_out1", data_out1, 32'h41424344);
    chk("sb_out2", data_out2, 32'h45464748);

    // mid-operation reset
    data_in1 = 32'hCAFEF00D; data_in2 = 32'h0BADBEEF; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (49) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("mr_out1", data_out1, 32'h0);
    chk("mr_out2", data_out2, 32'h0);
    chk("mr_busy", {31'b0, busy}, 32'h0);
    chk("mr_done", {31'b0, all_done}, 32'h0);
    @(negedge clock);
    chk("mr_idle_busy", {31'b0, busy}, 32'h0);
    ct_b = enc_model(32'h01234567, 32'h89ABCDEF, key_rt, 32);
    run32(ct_b[63:32], ct_b[31:0], -1, 32'h0, 32'h0, rise, busy_low);
    chk("mr_latency", 32'(rise), 32'd97);
    chk("mr_out1_after", data_out1, 32'h01234567);
    chk("mr_out2_after", data_out2, 32'h89ABCDEF);

    // back-to-back, one round
    key1 = key_rt;
    exp_a = dec_model(32'h11111111, 32'h22222222, key_rt, 1);
    exp_b = dec_model(32'hA5A5A5A5, 32'h5A5A5A5A, key_rt, 1);
    d1_in1 = 32'h11111111; d1_in2 = 32'h22222222; start1 = 1'b1;
    @(negedge clock);
    d1_in1 = 32'hA5A5A5A5; d1_in2 = 32'h5A5A5A5A;
    o4_1 = '0; o4_2 = '0; o9_1 = '0; o9_2 = '0;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clock);
      ad[n] = all_done1;
      if (n == 4) begin o4_1 = d1_out1; o4_2 = d1_out2; end
      if (n == 5) start1 = 1'b0;
      if (n == 9) begin o9_1 = d1_out1; o9_2 = d1_out2; end
    end
    chk("bb_done_e3", {31'b0, ad[3]}, 32'h0);
    chk("bb_done_e4", {31'b0, ad[4]}, 32'h1);
    chk("bb_done_e5", {31'b0, ad[5]}, 32'h0);
    chk("bb_done_e8", {31'b0, ad[8]}, 32'h0);
    chk("bb_done_e9", {31'b0, ad[9]}, 32'h1);
    chk("bb_done_e12", {31'b0, ad[12]}, 32'h1);
    chk("bb_a_out1", o4_1, exp_a[63:32]);
    chk("bb_a_out2", o4_2, exp_a[31:0]);
    chk("bb_b_out1", o9_1, exp_b[63:32]);
    chk("bb_b_out2", o9_2, exp_b[31:0]);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
